// File: rtl/byte_lane_sched.sv
// byte_lane_sched: round-robin arbiter and sequencer for a shared byte-lane datapath
module byte_lane_sched #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_a,
  input  logic          req_b,
  input  logic [1:0]    op_a,
  input  logic [1:0]    op_b,
  input  logic [CW-1:0] cnt_a,
  input  logic [CW-1:0] cnt_b,
  output logic          gnt_a,
  output logic          gnt_b,
  output logic          sel,
  output logic          mode_q,
  output logic          mode_r,
  output logic          mode_s,
  output logic          busy,
  output logic          done
);
  typedef enum logic [1:0] {IDLE, GRANT, RUN, DONE} state_t;
  state_t state, nxt;
  logic win, last;
  logic [1:0] op;
  logic [CW-1:0] cnt, ctr;
  logic win_nxt, run_end;
  assign win_nxt = (req_a & req_b) ? ~last : req_b;
  assign run_end = (op == 2'b00) || (ctr == '0);
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : nxt;
  // capture winner's operation, run the repeat counter, remember last grant
  always_ff @(posedge clk) begin
    if (rst) begin
      win  <= 1'b0;
      last <= 1'b1;
      op   <= 2'b00;
      cnt  <= '0;
      ctr  <= '0;
    end else begin
      if (state == IDLE && (req_a || req_b)) begin
        win <= win_nxt;
        op  <= win_nxt ? op_b : op_a;
        cnt <= win_nxt ? cnt_b : cnt_a;
      end
      if (state == GRANT) ctr <= cnt;
      if (state == RUN && !run_end) ctr <= ctr - 1'b1;
      if (state == DONE) last <= win;
    end
  end
  // next-state decode
  always_comb
    nxt = state == IDLE  ? ((req_a || req_b) ? GRANT : IDLE) :
          state == GRANT ? RUN :
          state == RUN   ? (run_end ? DONE : RUN) : IDLE;
  // outputs decoded purely from registered state, so no input reaches them combinationally
  always_comb begin
    busy  = (state == GRANT) || (state == RUN);
    gnt_a = busy && !win;
    gnt_b = busy && win;
    sel   = win;
    done  = state == DONE;
    {mode_q, mode_r, mode_s} = state != RUN ? 3'b000 :
                               op == 2'b00  ? 3'b100 :
                               op == 2'b01  ? 3'b110 :
                               op == 2'b10  ? 3'b101 : 3'b000;
  end
endmodule

// File: tb/tb_byte_lane_sched.sv
// tb_byte_lane_sched: directed and randomized transactions against a transaction-level model
module tb_byte_lane_sched;
  localparam int CW = 3;
  logic clk = 1'b0, rst = 1'b1;
  logic req_a = 0, req_b = 0;
  logic [1:0] op_a = 0, op_b = 0;
  logic [CW-1:0] cnt_a = 0, cnt_b = 0;
  logic gnt_a, gnt_b, sel, mode_q, mode_r, mode_s, busy, done;
  int checks = 0, errors = 0;
  logic m_last = 1'b1, m_sel = 1'b0;

  byte_lane_sched #(.CW(CW)) dut (
    .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .op_a(op_a), .op_b(op_b),
    .cnt_a(cnt_a), .cnt_b(cnt_b), .gnt_a(gnt_a), .gnt_b(gnt_b), .sel(sel),
    .mode_q(mode_q), .mode_r(mode_r), .mode_s(mode_s), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] modes(input logic [1:0] o);
    return o == 2'b00 ? 3'b100 : o == 2'b01 ? 3'b110 : o == 2'b10 ? 3'b101 : 3'b000;
  endfunction

  task automatic chk(input string tag, input logic [7:0] exp);
    logic [7:0] obs;
    obs = {gnt_a, gnt_b, sel, mode_q, mode_r, mode_s, busy, done};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b (gnt_a gnt_b sel q r s busy done)", tag, obs, exp);
    end
    checks++;
    assert ((gnt_a & gnt_b) === 1'b0) else begin
      errors++;
      $error("FAIL %s_onehot observed=%b%b expected=not both", tag, gnt_a, gnt_b);
    end
  endtask

  task automatic scramble();
    req_a = 1'($urandom);
    req_b = 1'($urandom);
    op_a  = 2'($urandom);
    op_b  = 2'($urandom);
    cnt_a = CW'($urandom);
    cnt_b = CW'($urandom);
  endtask

  task automatic txn(input logic ra, input logic rb, input logic [1:0] oa, input logic [1:0] ob,
                     input logic [CW-1:0] ca, input logic [CW-1:0] cb, input bit scr, input int abort_at);
    logic w;
    logic [1:0] o;
    int len;
    req_a = ra; req_b = rb; op_a = oa; op_b = ob; cnt_a = ca; cnt_b = cb;
    if (!ra && !rb) begin
      @(negedge clk);
      chk("idle_stay", {2'b00, m_sel, 5'b00000});
      return;
    end
    w = (ra && rb) ? ~m_last : rb;
    o = w ? ob : oa;
    len = (o == 2'b00) ? 1 : int'(w ? cb : ca) + 1;
    @(negedge clk);
    chk("grant", {~w, w, w, 3'b000, 2'b10});
    if (scr) scramble();
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      chk("run", {~w, w, w, modes(o), 2'b10});
      if (scr) scramble();
      if (k == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        chk("abort", 8'h00);
        rst = 1'b0;
        m_last = 1'b1;
        m_sel = 1'b0;
        return;
      end
    end
    @(negedge clk);
    chk("done", {2'b00, w, 3'b000, 2'b01});
    m_last = w;
    m_sel = w;
    @(negedge clk);
    chk("idle", {2'b00, w, 5'b00000});
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset", 8'h00);
    rst = 1'b0;
    txn(0, 0, 2'b00, 2'b00, 0, 0, 0, -1);
    txn(1, 0, 2'b01, 2'b00, 2, 0, 0, -1);
    for (int i = 0; i < 4; i++) txn(1, 1, 2'b00, 2'b00, 3, 5, 0, -1);
    txn(0, 1, 2'b01, 2'b00, 0, 7, 0, -1);
    txn(1, 0, 2'b10, 2'b00, 7, 0, 0, -1);
    txn(1, 0, 2'b11, 2'b01, 3, 6, 1, -1);
    txn(1, 0, 2'b01, 2'b00, 2, 0, 1, 2);
    txn(1, 1, 2'b10, 2'b01, 1, 1, 0, -1);
    txn(1, 1, 2'b00, 2'b01, 0, 2, 1, -1);
    for (int i = 0; i < 40; i++)
      txn(1'($urandom), 1'($urandom), 2'($urandom), 2'($urandom),
          CW'($urandom), CW'($urandom), 1'($urandom), -1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
